// File: rtl/ren_conv_wb_sequencer.sv
// Wishbone master that drives one convolver instance through a complete job:
// stream image and kernel words in, program the config registers, start the
// engine, poll for completion, stream the result bytes out, then clean up
// with a soft reset.
module ren_conv_wb_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned POLL_GAP  = 10,
    parameter int unsigned POLL_MAX  = 100
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_start_i,
    input  logic [1:0]  cmd_inst_i,
    input  logic [31:0] cmd_cfg1_i,
    input  logic [31:0] cmd_cfg2_i,
    input  logic [5:0]  cmd_img_words_i,
    input  logic [5:0]  cmd_kern_words_i,
    input  logic [5:0]  cmd_res_words_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [23:0] in_data_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [7:0]  res_data_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_IMG      = 4'd1;
    localparam logic [3:0] S_KERN     = 4'd2;
    localparam logic [3:0] S_CFG1     = 4'd3;
    localparam logic [3:0] S_CFG2     = 4'd4;
    localparam logic [3:0] S_GO       = 4'd5;
    localparam logic [3:0] S_POLL     = 4'd6;
    localparam logic [3:0] S_GAP      = 4'd7;
    localparam logic [3:0] S_READ     = 4'd8;
    localparam logic [3:0] S_PUSH     = 4'd9;
    localparam logic [3:0] S_CLR      = 4'd10;
    localparam logic [3:0] S_SRST     = 4'd11;
    localparam logic [3:0] S_SRST_CLR = 4'd12;
    localparam logic [3:0] S_FIN      = 4'd13;

    localparam logic [31:0] OFF_REG0 = 32'h000;
    localparam logic [31:0] OFF_REG1 = 32'h004;
    localparam logic [31:0] OFF_REG2 = 32'h008;
    localparam logic [31:0] OFF_IMG  = 32'h100;
    localparam logic [31:0] OFF_KERN = 32'h200;
    localparam logic [31:0] OFF_RES  = 32'h300;

    logic [3:0]  state;
    logic [1:0]  inst_q;
    logic [31:0] cfg1_q;
    logic [31:0] cfg2_q;
    logic [5:0]  img_n;
    logic [5:0]  kern_n;
    logic [5:0]  res_n;
    logic [5:0]  idx;
    logic [15:0] poll_cnt;
    logic [15:0] gap_cnt;
    logic [7:0]  res_q;
    logic        busy_q;
    logic        err_q;

    logic        cyc_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;

    logic        open_req;
    logic        open_we;
    logic [31:0] open_adr;
    logic [31:0] open_dat;

    logic [31:0] inst_base;
    logic [31:0] idx_off;
    logic [5:0]  idx_next;
    logic        ack_ok;
    logic        unused_dat;

    assign inst_base  = BASE_ADDR + {6'd0, inst_q, 24'd0};
    assign idx_off    = {24'd0, idx, 2'b00};
    assign idx_next   = idx + 6'd1;
    // An ack only counts while our own cycle is open.
    assign ack_ok     = cyc_q & wbm_ack_i;
    assign unused_dat = &{1'b0, wbm_dat_i[31:8]};

    // Decide whether a new bus cycle opens on the next edge, and with what request.
    always_comb begin
        open_req = 1'b0;
        open_we  = 1'b0;
        open_adr = '0;
        open_dat = '0;
        if (!cyc_q) begin
            case (state)
                S_IMG: begin
                    open_req = in_valid_i;
                    open_we  = 1'b1;
                    open_adr = inst_base + OFF_IMG + idx_off;
                    open_dat = {8'd0, in_data_i};
                end
                S_KERN: begin
                    open_req = in_valid_i;
                    open_we  = 1'b1;
                    open_adr = inst_base + OFF_KERN + idx_off;
                    open_dat = {8'd0, in_data_i};
                end
                S_CFG1: begin
                    open_req = 1'b1;
                    open_we  = 1'b1;
                    open_adr = inst_base + OFF_REG1;
                    open_dat = cfg1_q;
                end
                S_CFG2: begin
                    open_req = 1'b1;
                    open_we  = 1'b1;
                    open_adr = inst_base + OFF_REG2;
                    open_dat = cfg2_q;
                end
                S_GO: begin
                    open_req = 1'b1;
                    open_we  = 1'b1;
                    open_adr = inst_base + OFF_REG0;
                    open_dat = 32'd4;
                end
                S_POLL: begin
                    open_req = 1'b1;
                    open_adr = inst_base + OFF_REG0;
                end
                S_READ: begin
                    open_req = 1'b1;
                    open_adr = inst_base + OFF_RES + idx_off;
                end
                S_CLR, S_SRST_CLR: begin
                    open_req = 1'b1;
                    open_we  = 1'b1;
                    open_adr = inst_base + OFF_REG0;
                end
                S_SRST: begin
                    open_req = 1'b1;
                    open_we  = 1'b1;
                    open_adr = inst_base + OFF_REG0;
                    open_dat = 32'd2;
                end
                default: ;
            endcase
        end
    end

    // Wishbone request registers: load on open, clear to zero the edge ack is seen.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
        end else if (ack_ok) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
        end else if (open_req) begin
            cyc_q <= 1'b1;
            we_q  <= open_we;
            adr_q <= open_adr;
            dat_q <= open_dat;
        end
    end

    // Job sequencing; bus-driven states advance only on the ack of their own cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state    <= S_IDLE;
            inst_q   <= '0;
            cfg1_q   <= '0;
            cfg2_q   <= '0;
            img_n    <= '0;
            kern_n   <= '0;
            res_n    <= '0;
            idx      <= '0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
            res_q    <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_start_i) begin
                        inst_q <= cmd_inst_i;
                        cfg1_q <= cmd_cfg1_i;
                        cfg2_q <= cmd_cfg2_i;
                        img_n  <= cmd_img_words_i;
                        kern_n <= cmd_kern_words_i;
                        res_n  <= cmd_res_words_i;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        err_q  <= 1'b0;
                        if (cmd_img_words_i != 6'd0)
                            state <= S_IMG;
                        else if (cmd_kern_words_i != 6'd0)
                            state <= S_KERN;
                        else
                            state <= S_CFG1;
                    end
                end
                S_IMG: begin
                    if (ack_ok) begin
                        if (idx_next == img_n) begin
                            idx   <= '0;
                            state <= (kern_n != 6'd0) ? S_KERN : S_CFG1;
                        end else begin
                            idx <= idx_next;
                        end
                    end
                end
                S_KERN: begin
                    if (ack_ok) begin
                        if (idx_next == kern_n) begin
                            idx   <= '0;
                            state <= S_CFG1;
                        end else begin
                            idx <= idx_next;
                        end
                    end
                end
                S_CFG1: if (ack_ok) state <= S_CFG2;
                S_CFG2: if (ack_ok) state <= S_GO;
                S_GO: begin
                    if (ack_ok) begin
                        poll_cnt <= '0;
                        state    <= S_POLL;
                    end
                end
                S_POLL: begin
                    if (ack_ok) begin
                        if (wbm_dat_i[0]) begin
                            idx   <= '0;
                            state <= (res_n != 6'd0) ? S_READ : S_CLR;
                        end else if (32'(poll_cnt) + 32'd1 >= POLL_MAX) begin
                            err_q <= 1'b1;
                            state <= S_CLR;
                        end else begin
                            poll_cnt <= poll_cnt + 16'd1;
                            gap_cnt  <= '0;
                            state    <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (32'(gap_cnt) + 32'd1 >= POLL_GAP)
                        state <= S_POLL;
                    else
                        gap_cnt <= gap_cnt + 16'd1;
                end
                S_READ: begin
                    if (ack_ok) begin
                        res_q <= wbm_dat_i[7:0];
                        state <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (res_ready_i) begin
                        if (idx_next == res_n) begin
                            idx   <= '0;
                            state <= S_CLR;
                        end else begin
                            idx   <= idx_next;
                            state <= S_READ;
                        end
                    end
                end
                S_CLR:      if (ack_ok) state <= S_SRST;
                S_SRST:     if (ack_ok) state <= S_SRST_CLR;
                S_SRST_CLR: if (ack_ok) state <= S_FIN;
                S_FIN: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = ((state == S_IMG) || (state == S_KERN)) && !cyc_q;
    assign res_valid_o = (state == S_PUSH);
    assign res_data_o  = res_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = cyc_q ? 4'hF : 4'h0;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign busy_o      = busy_q;
    assign done_o      = (state == S_FIN);
    assign err_o       = err_q;

endmodule

// File: doc/ren_conv_wb_sequencer.md
REN_CONV_WB_SEQUENCER -- requirements
Module: ren_conv_wb_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000: register base of convolver instance 0; instance n at BASE_ADDR + (n<<24).
REQ-002 Parameter POLL_GAP, default 10: idle cycles between consecutive done-poll reads.
REQ-003 Parameter POLL_MAX, default 100: maximum done-poll reads before error.
REQ-004 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-005 wb_rst_i  in  1  reset, asynchronous assert, active-low; synchronous deassert.
REQ-006 cmd_start_i  in  1  one-cycle job start pulse.
REQ-007 cmd_inst_i  in  2  target convolver instance.
REQ-008 cmd_cfg1_i / cmd_cfg2_i  in  32 each  words written to instance regs at +4 and +8.
REQ-009 cmd_img_words_i / cmd_kern_words_i / cmd_res_words_i  in  6 each  word counts (0 = skip phase).
REQ-010 in_valid_i / in_ready_o / in_data_i  in/out/in  1/1/24  image-then-kernel word stream.
REQ-011 res_valid_o / res_ready_i / res_data_o  out/in/out  1/1/8  result byte stream.
REQ-012 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each; wbm_sel_o out 4; wbm_adr_o out 32; wbm_dat_o out 32: Wishbone master request.
REQ-013 wbm_ack_i in 1; wbm_dat_i in 32: Wishbone master response.
REQ-014 busy_o out 1 (job active); done_o out 1 (one-cycle completion pulse); err_o out 1 (sticky poll timeout, cleared on next accepted start).

Function
REQ-015 Address map per instance: reg0 +0x000 (bit0 done, bit1 soft reset, bit2 start), reg1 +0x004, reg2 +0x008, image +0x100+4i, kernel +0x200+4i, result +0x300+4i.
REQ-016 cmd_start_i SHALL be accepted only in IDLE; all cmd_* inputs latched at acceptance; start while busy ignored.
REQ-017 FSM states: IDLE, IMG, KERN, CFG1, CFG2, GO, POLL, GAP, READ, PUSH, CLR, SRST, SRST_CLR, FIN.
REQ-018 Order: IMG (img_words writes) -> KERN (kern_words writes) -> CFG1 (reg1=cfg1) -> CFG2 (reg2=cfg2) -> GO (reg0=4) -> POLL/GAP -> READ/PUSH per result -> CLR (reg0=0) -> SRST (reg0=2) -> SRST_CLR (reg0=0) -> FIN -> IDLE.
REQ-019 Phase with count 0 SHALL be skipped with no bus activity.
REQ-020 in_ready_o high only in IMG/KERN with no bus cycle open; word written as {8'd0,in_data_i}; bus cycle opens the cycle after the in handshake.
REQ-021 Bus cycle: cyc=stb=1, sel=4'hF, adr/dat/we stable until ack sampled high; cyc=stb=0 the cycle after ack; at least one idle cycle between cycles.
REQ-022 Outside cycles wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o SHALL be 0.
REQ-023 POLL reads reg0; ack with wbm_dat_i[0]=1 -> READ; else GAP holds POLL_GAP cycles then POLL again.
REQ-024 POLL_MAX-th read with done=0 -> err_o=1, skip READ, go to CLR (cleanup writes still issued), then FIN.
REQ-025 READ reads result word i; wbm_dat_i[7:0] captured at ack; PUSH holds res_valid_o=1 and res_data_o stable until res_ready_i; next read only after handshake.
REQ-026 done_o pulses exactly one cycle in FIN; busy_o high from cycle after acceptance through FIN.
REQ-027 Word index counters 6-bit; address = base + (index<<2); counter reaching latched count ends phase, no wrap.
REQ-028 wbm_ack_i outside an open cycle SHALL be ignored.

Reset
REQ-029 Async reset assert (wb_rst_i=0) SHALL immediately force IDLE and all outputs to 0, including mid-bus-cycle (cyc dropped without ack); counters and err_o cleared.
REQ-030 After reset release, first start accepted no earlier than first rising edge with wb_rst_i=1.

Verification
REQ-031 Inst 0, img=32, kern=32, res=12, cfg1=0x01020701, cfg2=0x005F0C0B, slave done on 3rd poll -> writes at 0x3000_0100..017C, 0x3000_0200..027C, +4, +8, reg0=4, 3 reads reg0 spaced ≥10 idle cycles, 12 reads 0x3000_0300..032C, writes 0,2,0 to reg0, done_o one pulse.
REQ-032 Inst 3, img=0, kern=0, res=0 -> first bus address 0x3300_0004; no stream handshakes; done_o after SRST_CLR.
REQ-033 Slave never sets done -> exactly 100 poll reads, err_o=1, no result reads, cleanup 0,2,0 issued, done_o pulses; next start clears err_o.
REQ-034 res_ready_i low for 20 cycles on result 5 -> res_valid_o and res_data_o held stable, no bus cycle during stall.
REQ-035 Slave ack delayed 4 cycles; start pulsed while busy -> request signals stable until ack; second start ignored.
REQ-036 wb_rst_i low mid image write (cyc=1) -> same-cycle cyc=stb=0, busy_o=0, IDLE; fresh job completes normally.
